// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/valid bus between the fetch unit (master) and
// the instruction memory (slave). Vectors use big-endian bit numbering.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [0:31] imem_addr;
   logic [0:31] imem_rdata;
   logic        imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per instruction and
// holds it for decode until the datapath retires it via advance.
module instr_fetch_unit #(
   parameter logic [0:31]  RESET_PC = 32'h0000_0000,
   parameter int unsigned  PC_INC   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   instr_fetch_unit_if.master         imem_bus,
   input  logic                       advance,
   input  logic                       BRANCH,
   input  logic                       JUMP,
   input  logic                       jump_reg,
   input  logic                       branch_taken,
   input  logic [0:31]                reg_target,
   output logic [0:31]                instruction,
   output logic                       instr_valid,
   output logic [0:31]                pc,
   output logic [0:31]                pc_plus4,
   output logic                       align_err
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

   state_e      state_q, state_d;
   logic        req_q, req_d;
   logic [0:31] pc_q, pc_d;
   logic [0:31] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        align_err_q, align_err_d;

   logic [0:31] pc_inc;
   logic [0:31] jump_off;
   logic [0:31] branch_off;
   logic [0:31] next_pc;

   // Offsets are byte offsets taken from the low bits of the held word.
   always_comb begin
      pc_inc     = pc_q + 32'(PC_INC);
      jump_off   = {{6{instr_q[6]}}, instr_q[6:31]};
      branch_off = {{16{instr_q[16]}}, instr_q[16:31]};
      if (JUMP && jump_reg) begin
         next_pc = reg_target;
      end else if (JUMP) begin
         next_pc = pc_inc + jump_off;
      end else if (BRANCH && branch_taken) begin
         next_pc = pc_inc + branch_off;
      end else begin
         next_pc = pc_inc;
      end
   end

   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      align_err_d   = align_err_q;
      unique case (state_q)
         StIdle: begin
            state_d = StReq;
            req_d   = 1'b1;
         end
         StReq, StWait: begin
            if (imem_bus.imem_valid) begin
               instr_d       = imem_bus.imem_rdata;
               instr_valid_d = 1'b1;
               req_d         = 1'b0;
               state_d       = StHold;
            end else begin
               state_d = StWait;
            end
         end
         StHold: begin
            if (advance) begin
               pc_d          = {next_pc[0:29], 2'b00};
               align_err_d   = align_err_q | (|next_pc[30:31]);
               instr_valid_d = 1'b0;
               req_d         = 1'b1;
               state_d       = StReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         req_q         <= 1'b0;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0;
         instr_valid_q <= 1'b0;
         align_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         align_err_q   <= align_err_d;
      end
   end

   assign imem_bus.imem_req  = req_q;
   assign imem_bus.imem_addr = pc_q;
   assign instruction        = instr_q;
   assign instr_valid        = instr_valid_q;
   assign pc                 = pc_q;
   assign pc_plus4           = pc_inc;
   assign align_err          = align_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: the bench plays the instruction memory
// and the decoder, checking every observation against hand-computed values.
module tb_instr_fetch_unit;
   logic        clk;
   logic        rst_n;
   logic        advance;
   logic        BRANCH;
   logic        JUMP;
   logic        jump_reg;
   logic        branch_taken;
   logic [0:31] reg_target;
   logic [0:31] instruction;
   logic        instr_valid;
   logic [0:31] pc;
   logic [0:31] pc_plus4;
   logic        align_err;

   int n_assert = 0;
   int n_fail   = 0;

   instr_fetch_unit_if imem_bus ();

   instr_fetch_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_bus     (imem_bus),
      .advance      (advance),
      .BRANCH       (BRANCH),
      .JUMP         (JUMP),
      .jump_reg     (jump_reg),
      .branch_taken (branch_taken),
      .reg_target   (reg_target),
      .instruction  (instruction),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .align_err    (align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called in REQ: check the request, answer it in the same cycle, then check the hold.
   task automatic resp(input logic [31:0] addr, input logic [31:0] data);
      chk("resp_req", 32'(imem_bus.imem_req), 32'd1);
      chk("resp_addr", imem_bus.imem_addr, addr);
      imem_bus.imem_valid = 1'b1;
      imem_bus.imem_rdata = data;
      step();
      imem_bus.imem_valid = 1'b0;
      chk("hold_ivalid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instruction, data);
      chk("hold_pc", pc, addr);
      chk("hold_req", 32'(imem_bus.imem_req), 32'd0);
   endtask

   initial begin
      rst_n               = 1'b0;
      advance             = 1'b0;
      BRANCH              = 1'b0;
      JUMP                = 1'b0;
      jump_reg            = 1'b0;
      branch_taken        = 1'b0;
      reg_target          = 32'h0;
      imem_bus.imem_valid = 1'b0;
      imem_bus.imem_rdata = 32'h0;
      step();
      step();
      chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_ivalid", 32'(instr_valid), 32'd0);
      chk("rst_align", 32'(align_err), 32'd0);

      // Reset release, two-cycle memory latency.
      rst_n = 1'b1;
      chk("idle_req", 32'(imem_bus.imem_req), 32'd0);
      step();
      chk("req_start", 32'(imem_bus.imem_req), 32'd1);
      chk("req_addr", imem_bus.imem_addr, 32'h0);
      step();
      chk("wait_ivalid", 32'(instr_valid), 32'd0);
      resp(32'h0, 32'h2001_0005);
      chk("pc_plus4_0", pc_plus4, 32'h4);
      advance = 1'b1;
      step();
      advance = 1'b0;
      chk("retire_ivalid", 32'(instr_valid), 32'd0);

      // Zero-latency memory, advance held high: one instruction per two cycles.
      advance = 1'b1;
      resp(32'h4, 32'h0);
      step();
      BRANCH       = 1'b1;
      branch_taken = 1'b1;
      resp(32'h8, 32'h1000_FFF4);   // 12 + (-12)
      step();
      BRANCH       = 1'b0;
      branch_taken = 1'b0;
      chk("br_taken_addr", imem_bus.imem_addr, 32'h0);

      resp(32'h0, 32'h0);
      step();
      resp(32'h4, 32'h0);
      step();
      BRANCH = 1'b1;
      resp(32'h8, 32'h1000_FFF4);
      step();
      BRANCH = 1'b0;
      chk("br_not_taken_addr", imem_bus.imem_addr, 32'hC);
      resp(32'hC, 32'h0);
      step();

      // J with imm26 = 0x100 at pc 16 -> 20 + 0x100.
      JUMP = 1'b1;
      resp(32'h10, 32'h0800_0100);
      step();
      chk("jump_addr", imem_bus.imem_addr, 32'h114);
      chk("jump_align", 32'(align_err), 32'd0);

      jump_reg   = 1'b1;
      reg_target = 32'h0000_0203;
      resp(32'h114, 32'h0);
      step();
      JUMP     = 1'b0;
      jump_reg = 1'b0;
      chk("jr_addr", imem_bus.imem_addr, 32'h200);
      chk("jr_align", 32'(align_err), 32'd1);
      resp(32'h200, 32'h0);
      step();
      chk("align_sticky", 32'(align_err), 32'd1);

      // Wrap: JR to the last word, then sequential fetch wraps to zero.
      JUMP       = 1'b1;
      jump_reg   = 1'b1;
      reg_target = 32'hFFFF_FFFC;
      resp(32'h204, 32'h0);
      step();
      JUMP     = 1'b0;
      jump_reg = 1'b0;
      resp(32'hFFFF_FFFC, 32'h0);
      chk("wrap_pc_plus4", pc_plus4, 32'h0);
      step();
      advance = 1'b0;
      chk("wrap_addr", imem_bus.imem_addr, 32'h0);

      // Long hold with spurious responses.
      resp(32'h0, 32'hDEAD_BEEC);
      for (int i = 0; i < 10; i++) begin
         imem_bus.imem_valid = i[0];
         imem_bus.imem_rdata = 32'hBAD0_0000 + 32'(i);
         step();
         chk("hold_no_req", 32'(imem_bus.imem_req), 32'd0);
      end
      imem_bus.imem_valid = 1'b0;
      chk("hold_instr_kept", instruction, 32'hDEAD_BEEC);
      chk("hold_pc_kept", pc, 32'h0);
      chk("hold_ivalid_kept", 32'(instr_valid), 32'd1);
      advance = 1'b1;
      step();
      advance = 1'b0;
      chk("after_hold_req", 32'(imem_bus.imem_req), 32'd1);
      chk("after_hold_addr", imem_bus.imem_addr, 32'h4);

      // Reset during WAIT; a late response lands in IDLE and is dropped.
      step();
      chk("wait2_req", 32'(imem_bus.imem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst2_req", 32'(imem_bus.imem_req), 32'd0);
      chk("rst2_pc", pc, 32'h0);
      chk("rst2_instr", instruction, 32'h0);
      chk("rst2_ivalid", 32'(instr_valid), 32'd0);
      chk("rst2_align", 32'(align_err), 32'd0);
      step();
      rst_n               = 1'b1;
      imem_bus.imem_valid = 1'b1;
      imem_bus.imem_rdata = 32'hBAD0_BAD0;
      step();
      imem_bus.imem_valid = 1'b0;
      chk("late_ivalid", 32'(instr_valid), 32'd0);
      chk("late_instr", instruction, 32'h0);
      resp(32'h0, 32'h1111_1110);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
